// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader that writes instruction memory, verifies by XOR read-back checksum, then releases the core
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              WE,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       WD,
    input  logic [31:0]       RD,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_CHECK_LEN,
        S_COLLECT,
        S_WRITE,
        S_VERIFY_ADDR,
        S_VERIFY_SAMPLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic [15:0] n;
    logic [8:0]  idx;
    logic [8:0]  idx_inc;
    logic [1:0]  bidx;
    logic [23:0] part;
    logic [31:0] wsum;
    logic [31:0] rsum;
    logic        hs;
    logic        start_ok;
    logic        last_word;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
    assign hs        = byte_valid && byte_ready;
    assign idx_inc   = idx + 9'd1;
    // idx_inc == N means idx addresses the final word of the program
    assign last_word = ({7'd0, idx_inc} == n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_HDR_LO;
            S_HDR_LO:        if (hs) state_next = S_HDR_HI;
            S_HDR_HI:        if (hs) state_next = S_CHECK_LEN;
            S_CHECK_LEN: begin
                if (n == 16'd0)                  state_next = S_DONE;
                else if (n > 16'(MAX_WORDS))     state_next = S_ERROR;
                else                             state_next = S_COLLECT;
            end
            S_COLLECT:       if (hs && bidx == 2'd3) state_next = S_WRITE;
            S_WRITE:         state_next = last_word ? S_VERIFY_ADDR : S_COLLECT;
            S_VERIFY_ADDR:   state_next = S_VERIFY_SAMPLE;
            S_VERIFY_SAMPLE: begin
                if (!last_word)                  state_next = S_VERIFY_ADDR;
                else if ((rsum ^ RD) == wsum)    state_next = S_DONE;
                else                             state_next = S_ERROR;
            end
            default:         state_next = S_IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == S_HDR_LO) || (state == S_HDR_HI) || (state == S_COLLECT);
        WE         = (state == S_WRITE);
        busy       = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
        done       = (state == S_DONE);
        error      = (state == S_ERROR);
        cpu_rst_n  = (state == S_DONE);
    end

    // A and WD are registered one cycle ahead so they are stable for the whole WRITE/VERIFY_ADDR cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n    <= '0;
            idx  <= '0;
            bidx <= '0;
            part <= '0;
            wsum <= '0;
            rsum <= '0;
            A    <= '0;
            WD   <= '0;
        end else if (start_ok) begin
            n    <= '0;
            idx  <= '0;
            bidx <= '0;
            wsum <= '0;
            rsum <= '0;
        end else begin
            case (state)
                S_HDR_LO: if (hs) n[7:0]  <= byte_data;
                S_HDR_HI: if (hs) n[15:8] <= byte_data;
                S_COLLECT: begin
                    if (hs) begin
                        bidx <= bidx + 2'd1;
                        case (bidx)
                            2'd0: part[7:0]   <= byte_data;
                            2'd1: part[15:8]  <= byte_data;
                            2'd2: part[23:16] <= byte_data;
                            default: begin
                                WD <= {byte_data, part};
                                A  <= ADDR_W'({idx, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    wsum <= wsum ^ WD;
                    if (last_word) begin
                        idx <= '0;
                        A   <= '0;
                    end else begin
                        idx <= idx_inc;
                    end
                end
                S_VERIFY_SAMPLE: begin
                    rsum <= rsum ^ RD;
                    if (!last_word) begin
                        idx <= idx_inc;
                        A   <= ADDR_W'({idx_inc, 2'b00});
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a program-level reference model
module tb_imem_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              WE;
    logic [ADDR_W-1:0] A;
    logic [31:0]       WD;
    logic [31:0]       RD;
    logic              busy, done, error, cpu_rst_n;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .WE(WE), .A(A), .WD(WD),
        .RD(RD), .busy(busy), .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    // Synchronous memory: RD reflects the address presented on the previous edge
    logic [31:0] mem [0:255];
    bit          corrupt = 1'b0;
    always @(posedge clk) begin
        if (WE) mem[A[9:2]] <= WD;
        RD <= (corrupt && A[9:2] == 8'd3) ? 32'h40e00594 : mem[A[9:2]];
    end

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    bit                we_prev = 1'b0;
    bit                feeding = 1'b0;
    int                proto_err = 0;
    int                checks = 0;
    int                errors = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (WE) begin
                wr_addr.push_back(A);
                wr_data.push_back(WD);
                if (we_prev) proto_err++;
            end
            if (byte_ready && (WE || !busy || !feeding)) proto_err++;
            we_prev = WE;
        end else begin
            we_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b[$], input bit rnd, input bit inject);
        int  k = 0;
        int  budget = 0;
        bit  hs;
        bit  injected = 1'b0;
        while (k < b.size() && budget < 20000) begin
            @(negedge clk);
            start      = (inject && !injected && k == 5);
            if (start) injected = 1'b1;
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = byte_valid ? b[k] : 8'($urandom);
            hs         = byte_valid && byte_ready;
            @(posedge clk);
            if (hs) k++;
            budget++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        check("feed_complete", 32'(k), 32'(b.size()));
    endtask

    task automatic wait_result(input int budget);
        int c = 0;
        while (!(done || error) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("result_in_time", 32'(done || error), 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference model: program-level expectations derived from length and memory behaviour
    task automatic run(input logic [31:0] w[$], input int n, input bit rnd,
                       input bit corrupt_in, input bit inject, input int budget);
        logic [7:0]  b[$];
        logic [15:0] nn;
        int          exp_writes;
        bit          exp_done;
        nn = 16'(n);
        b.push_back(nn[7:0]);
        b.push_back(nn[15:8]);
        if (n <= MAX_WORDS)
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 4; j++) b.push_back(8'(w[i] >> (8 * j)));
        exp_writes = (n >= 1 && n <= MAX_WORDS) ? n : 0;
        exp_done   = (n == 0) || (n <= MAX_WORDS && !(corrupt_in && n > 3));
        corrupt    = corrupt_in;
        feeding    = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        feed(b, rnd, inject);
        feeding = 1'b0;
        wait_result(budget);
        check("write_count", 32'(wr_addr.size()), 32'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_addr.size(); i++) begin
            check($sformatf("write_addr[%0d]", i), 32'(wr_addr[i]), 32'((i * 4) % (1 << ADDR_W)));
            check($sformatf("write_data[%0d]", i), wr_data[i], w[i]);
        end
        check("done", 32'(done), 32'(exp_done));
        check("error", 32'(error), 32'(!exp_done));
        check("cpu_rst_n", 32'(cpu_rst_n), 32'(exp_done));
        check("busy_idle", 32'(busy), 32'd0);
        check("protocol", 32'(proto_err), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"}, 32'(WE), 32'd0);
        check({tag, "_a"}, 32'(A), 32'd0);
        check({tag, "_wd"}, WD, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    endtask

    initial begin
        logic [31:0] prog[$];
        logic [31:0] rnd_prog[$];
        logic [7:0]  part_b[$];
        int          c;
        int          rn;

        prog = '{32'h010000df, 32'h0800006f, 32'h40000513, 32'h40e00593, 32'h000006b3, 32'h04b50863};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");

        run(prog, 6, 1'b0, 1'b0, 1'b0, 200);
        run(prog, 6, 1'b1, 1'b0, 1'b1, 200);
        run(prog, 0, 1'b0, 1'b0, 1'b0, 3);
        run(prog, 300, 1'b0, 1'b0, 1'b0, 10);
        run(prog, 6, 1'b1, 1'b1, 1'b0, 200);
        run(prog, 6, 1'b0, 1'b0, 1'b0, 200);

        for (int t = 0; t < 3; t++) begin
            rn = $urandom_range(1, 9);
            rnd_prog.delete();
            for (int i = 0; i < rn; i++) rnd_prog.push_back($urandom);
            run(rnd_prog, rn, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 400);
        end

        rnd_prog.delete();
        for (int i = 0; i < MAX_WORDS; i++) rnd_prog.push_back($urandom);
        run(rnd_prog, MAX_WORDS, 1'b0, 1'b0, 1'b0, 2000);
        run(rnd_prog, MAX_WORDS + 1, 1'b0, 1'b0, 1'b0, 10);

        // Reset after the third write, then rerun the whole load
        corrupt = 1'b0;
        feeding = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        part_b = '{8'h06, 8'h00};
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) part_b.push_back(8'(prog[i] >> (8 * j)));
        pulse_start();
        feed(part_b, 1'b1, 1'b0);
        c = 0;
        while (wr_addr.size() < 3 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("third_write_seen", 32'(wr_addr.size()), 32'd3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        feeding = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        check_reset_outputs("post_reset");
        check("post_reset_writes", 32'(wr_addr.size()), 32'd0);
        run(prog, 6, 1'b0, 1'b0, 1'b0, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
